// File: rtl/n_carry_skip_adder_pkg.sv
// Shared constants for the registered carry-skip adder.
// Default width/block and a block-count helper used by the top level.
package n_carry_skip_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_BLOCK = 4;

    function automatic int num_blocks(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/n_carry_skip_adder_carry_skip_block.sv
// One ripple block with block-propagate detection and a skip mux on its carry-out.
// When every bit propagates, the incoming carry bypasses the ripple chain.
module carry_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] sum,
    output logic             c_out
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             blk_p;

    assign p     = a ^ b;
    assign g     = a & b;
    assign blk_p = &p;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[BLOCK-1:0];
    assign c_out = blk_p ? c_in : c[BLOCK];

endmodule

// File: rtl/n_carry_skip_adder.sv
// Registered N-bit carry-skip adder: chained skip blocks feeding a one-cycle output stage.
// Outputs clear asynchronously on rst and reload every rising clk.
module n_carry_skip_adder
    import n_carry_skip_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NB = num_blocks(WIDTH, BLOCK);

    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_param_chk
        $error("n_carry_skip_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic [NB:0]      carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    assign carry[0] = c_in;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        carry_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a     (a[k*BLOCK +: BLOCK]),
            .b     (b[k*BLOCK +: BLOCK]),
            .c_in  (carry[k]),
            .sum   (sum_d[k*BLOCK +: BLOCK]),
            .c_out (carry[k+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= carry[NB];
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_n_carry_skip_adder.sv
// Bench for n_carry_skip_adder: five 16-bit instances with BLOCK = 1,2,4,8,16
// driven in lockstep and compared against plain 17-bit addition.
module tb_n_carry_skip_adder;

    localparam int W  = 16;
    localparam int ND = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          c_in;
    logic [W-1:0]  sum_o [ND];
    logic          c_out_o [ND];

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        n_carry_skip_adder #(.WIDTH(W), .BLOCK(1 << gi)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .a     (a),
            .b     (b),
            .c_in  (c_in),
            .sum   (sum_o[gi]),
            .c_out (c_out_o[gi])
        );
    end

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got c_out=%b sum=0x%04h, want c_out=%b sum=0x%04h",
                     tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic check_all(input string tag, input logic [W:0] exp);
        for (int i = 0; i < ND; i++)
            check($sformatf("%s/B%0d", tag, 1 << i), {c_out_o[i], sum_o[i]}, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // Drive at negedge, sample just after the following posedge.
    task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic [W:0] exp);
        @(negedge clk);
        a = x; b = y; c_in = ci;
        @(posedge clk);
        #1;
        check_all(tag, exp);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;

        rst = 1'b1; a = 16'h1234; b = 16'h0001; c_in = 1'b0;
        #2;
        check_all("reset_hold", 17'h0_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_release", 17'h0_1235);

        step("carry_out",  16'hFFFF, 16'h8000, 1'b0, 17'h1_7FFF);
        step("skip_ci1",   16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        step("skip_ci0",   16'hFFFF, 16'h0000, 1'b0, 17'h0_FFFF);
        step("nocarry",    16'h1234, 16'h4321, 1'b0, 17'h0_5555);
        step("alt_ci1",    16'hAAAA, 16'h5555, 1'b1, 17'h1_0000);
        step("pipe0",      16'h0001, 16'h0001, 1'b0, 17'h0_0002);
        step("pipe1",      16'h00FF, 16'h0001, 1'b0, 17'h0_0100);
        step("pipe2",      16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);

        // Reset mid-operation: outputs clear without an edge, then resume.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        rst = 1'b1;
        #1;
        check_all("reset_mid", 17'h0_0000);
        @(posedge clk);
        #1;
        check_all("reset_mid_held", 17'h0_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_mid_release", 17'h1_FFFF);

        for (int n = 0; n < 10000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (n % 16 == 0) rb = ~ra;
            step("random", ra, rb, rc, ref_add(ra, rb, rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/n_carry_skip_adder.md
# n_carry_skip_adder

Registered N-bit carry-skip adder: sums two unsigned operands plus a carry-in through a chain of fixed-size ripple blocks with per-block skip multiplexers. Results appear on registered outputs one clock after the operands are presented. It is a standalone datapath leaf used wherever a fast, area-cheap adder with a one-cycle pipeline stage is needed; the default configuration is 16 bits.

## Interface
- WIDTH, 16: operand and sum width in bits; must be a positive multiple of BLOCK.
- BLOCK, 4: bits per ripple/skip block; 1 ≤ BLOCK ≤ WIDTH.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- Combinational core: WIDTH/BLOCK blocks, block k covering bits [k·BLOCK+BLOCK-1 : k·BLOCK].
- Per block:
  - p_i = a_i ^ b_i and g_i = a_i & b_i.
  - Ripple carry: c_{i+1} = g_i | (p_i & c_i); sum_i = p_i ^ c_i.
  - Block propagate P = AND of the block's p_i.
  - Block carry-out = P ? block carry-in : ripple carry-out. This skip mux is mandatory, not optional.
- Carry into block 0 is c_in. Carry into block k+1 is block k's muxed carry-out. c_out is the last block's muxed carry-out.
- The functional result must equal {c_out, sum} = a + b + c_in, computed at WIDTH+1 bits, for every input combination.
- Registers:
  - sum_q and c_out_q load the combinational result on every rising clk. There is no enable.
  - sum = sum_q and c_out = c_out_q.
- Reset: while rst = 1, sum = 0 and c_out = 0, immediately and asynchronously. The first capture occurs on the first rising clk after rst deasserts.
- No overflow or signed flag. The signed-overflow interpretation is left to the consumer.

## Timing
- Latency: 1 cycle. Operands stable before rising edge n produce sum and c_out valid after edge n and held until edge n+1.
- Throughput: one new addition per cycle. Back-to-back operand changes each cycle are legal.
- Reset mid-operation: an in-flight result is discarded and outputs go to 0 at once. After release, the outputs reflect the operands sampled at the next edge.
- Critical path is bounded by one block ripple + (WIDTH/BLOCK − 1) skip muxes + the last block's ripple. Inputs must meet setup relative to clk.
- All-propagate case (a ^ b = all ones): the carry passes from c_in to c_out through skip muxes only.

## Structure
- No shared package typedefs are required. WIDTH and BLOCK are module parameters. A package constant for the default width (16) is optional.
- One natural sub-module: carry_skip_block, parameter BLOCK.
  - Ports: a, b, c_in, sum, c_out.
  - Contains the ripple chain, the block-propagate AND and the skip mux.
- Top level:
  - Generate-instantiates WIDTH/BLOCK carry_skip_block instances chained on carry.
  - Holds the output registers and the reset logic.
- Parameter legality (WIDTH % BLOCK == 0) is checked at elaboration. An illegal setting fails elaboration.

## Test plan
- Reset: assert rst with a = 0x1234, b = 0x0001. Require sum = 0x0000 and c_out = 0 without a clock edge. Release rst and apply a clk edge; require sum = 0x1235 and c_out = 0.
- Basic carry out: a = 0xFFFF, b = 0x8000, c_in = 0. After one edge require sum = 0x7FFF and c_out = 1.
- Full skip path: a = 0xFFFF, b = 0x0000, c_in = 1. Require sum = 0x0000 and c_out = 1. With c_in = 0, require sum = 0xFFFF and c_out = 0.
- No-carry mix: a = 0x1234, b = 0x4321, c_in = 0. Require sum = 0x5555 and c_out = 0. Also a = 0xAAAA, b = 0x5555, c_in = 1; require sum = 0x0000 and c_out = 1.
- Pipeline: change operands every cycle over 0x0001+0x0001, 0x00FF+0x0001, 0x7FFF+0x0001. Require 0x0002, 0x0100 and 0x8000 on successive cycles, each one edge behind its operands, all with c_out = 0.
- Randomized: at least 10,000 random (a, b, c_in) sets at WIDTH = 16 with BLOCK ∈ {1, 2, 4, 8, 16}. Require {c_out, sum} = a + b + c_in, compared one cycle later.
